// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and op decoding for the iterative mul/div unit
package muldiv_pkg;

    typedef enum logic [1:0] {MULU = 2'd0, MULS = 2'd1, DIVU = 2'd2, DIVS = 2'd3} op_t;

    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2, DONE = 2'd3} state_t;

    function automatic logic op_is_div(input op_t o);
        return o == DIVU || o == DIVS;
    endfunction

    function automatic logic op_is_signed(input op_t o);
        return o == MULS || o == DIVS;
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one radix-2 shift-add (mul) or restoring trial-subtract (div) step on a shared adder
module muldiv_step #(
    parameter int WIDTH = 8
) (
    input  logic             div,
    input  logic [WIDTH-1:0] hi,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] hi_next,
    output logic [WIDTH-1:0] lo_next
);
    logic [WIDTH:0]   x;
    logic [WIDTH:0]   y;
    logic [WIDTH+1:0] sum;
    logic             ok;

    // Mul adds the multiplicand when the low bit is set; div subtracts the divisor via ~d + 1 and keeps it on carry-out
    always_comb begin
        x       = div ? {hi, lo[WIDTH-1]} : {1'b0, hi};
        y       = div ? ~{1'b0, d} : (lo[0] ? {1'b0, d} : '0);
        sum     = {1'b0, x} + {1'b0, y} + {{(WIDTH+1){1'b0}}, div};
        ok      = sum[WIDTH+1];
        hi_next = div ? (ok ? sum[WIDTH-1:0] : x[WIDTH-1:0]) : sum[WIDTH:1];
        lo_next = div ? {lo[WIDTH-2:0], ok} : {sum[0], lo[WIDTH-1:1]};
    end

endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative signed/unsigned multiplier/divider with valid/ready handshakes
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result_hi,
    output logic [WIDTH-1:0] result_lo,
    output logic             div_by_zero,
    output logic             overflow
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state;
    op_t              op_q;
    op_t              op_in;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] hi, lo, d, a_q;
    logic [WIDTH-1:0] hi_next, lo_next;
    logic [WIDTH-1:0] mag_a, mag_b, q_fix, r_fix;
    logic [2*WIDTH-1:0] prod_fix;
    logic             neg, sa, dz, ov;
    logic             sa_in, sb_in;

    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .div     (op_is_div(op_q)),
        .hi      (hi),
        .lo      (lo),
        .d       (d),
        .hi_next (hi_next),
        .lo_next (lo_next)
    );

    // Operand magnitudes and sign flags as seen at the accept edge
    always_comb begin
        op_in = op_t'(op);
        sa_in = op_is_signed(op_in) && a[WIDTH-1];
        sb_in = op_is_signed(op_in) && b[WIDTH-1];
        mag_a = sa_in ? -a : a;
        mag_b = sb_in ? -b : b;
    end

    // Sign restoration and special-case overrides applied in FIX
    always_comb begin
        prod_fix = neg ? -{hi, lo} : {hi, lo};
        q_fix    = dz ? '1 : ov ? a_q : neg ? -lo : lo;
        r_fix    = dz ? a_q : ov ? '0 : sa ? -hi : hi;
    end

    // Control FSM, step counter, accumulator and registered results
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            result_hi   <= '0;
            result_lo   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    state <= CALC;
                    op_q  <= op_in;
                    cnt   <= CW'(WIDTH - 1);
                    hi    <= '0;
                    lo    <= op_is_div(op_in) ? mag_a : mag_b;
                    d     <= op_is_div(op_in) ? mag_b : mag_a;
                    a_q   <= a;
                    neg   <= sa_in ^ sb_in;
                    sa    <= sa_in;
                    dz    <= op_is_div(op_in) && b == '0;
                    ov    <= op_in == DIVS && a == MIN_NEG && b == '1;
                end
                CALC: begin
                    hi  <= hi_next;
                    lo  <= lo_next;
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) state <= FIX;
                end
                FIX: begin
                    state       <= DONE;
                    result_hi   <= op_is_div(op_q) ? r_fix : prod_fix[2*WIDTH-1:WIDTH];
                    result_lo   <= op_is_div(op_q) ? q_fix : prod_fix[WIDTH-1:0];
                    div_by_zero <= dz;
                    overflow    <= ov;
                end
                DONE: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: randomized and directed checks of muldiv_seq at WIDTH 8, 16 and 4
module tb_muldiv_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [1:0]  opv = '0;
    logic [31:0] av = '0;
    logic [31:0] bv = '0;
    int          sel = 0;
    int          passed = 0;
    int          total = 0;

    logic [2:0]  iv, ir, ovld, dzv, ofv;
    logic [7:0]  hi8, lo8;
    logic [15:0] hi16, lo16;
    logic [3:0]  hi4, lo4;
    logic [31:0] hi_m, lo_m;

    always #5 clk = ~clk;

    assign iv = in_valid ? 3'(3'b001 << sel) : 3'b000;

    muldiv_seq #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .op(opv), .a(av[7:0]), .b(bv[7:0]),
        .out_valid(ovld[0]), .out_ready(out_ready || sel != 0), .result_hi(hi8), .result_lo(lo8),
        .div_by_zero(dzv[0]), .overflow(ofv[0])
    );

    muldiv_seq #(.WIDTH(16)) u16 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .op(opv), .a(av[15:0]), .b(bv[15:0]),
        .out_valid(ovld[1]), .out_ready(out_ready || sel != 1), .result_hi(hi16), .result_lo(lo16),
        .div_by_zero(dzv[1]), .overflow(ofv[1])
    );

    muldiv_seq #(.WIDTH(4)) u4 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .op(opv), .a(av[3:0]), .b(bv[3:0]),
        .out_valid(ovld[2]), .out_ready(out_ready || sel != 2), .result_hi(hi4), .result_lo(lo4),
        .div_by_zero(dzv[2]), .overflow(ofv[2])
    );

    // Route the selected instance's results to common observation signals
    always_comb begin
        hi_m = sel == 1 ? 32'(hi16) : sel == 2 ? 32'(hi4) : 32'(hi8);
        lo_m = sel == 1 ? 32'(lo16) : sel == 2 ? 32'(lo4) : 32'(lo8);
    end

    function automatic int wid(input int k);
        return k == 1 ? 16 : k == 2 ? 4 : 8;
    endfunction

    function automatic logic [65:0] pack(input logic dz, input logic ov, input logic [31:0] h, input logic [31:0] l);
        return {dz, ov, h, l};
    endfunction

    // Reference: integer arithmetic on sign-extended values, truncating division
    function automatic logic [65:0] model(input int w, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        longint m  = (longint'(1) << w) - 1;
        longint ux = longint'(x) & m;
        longint uy = longint'(y) & m;
        longint sx = ux >= (longint'(1) << (w - 1)) ? ux - (longint'(1) << w) : ux;
        longint sy = uy >= (longint'(1) << (w - 1)) ? uy - (longint'(1) << w) : uy;
        longint p, q, r;
        logic dz = 1'b0, ov = 1'b0;
        if (o < 2) begin
            p = o == 1 ? sx * sy : ux * uy;
            return pack(1'b0, 1'b0, 32'((p >> w) & m), 32'(p & m));
        end
        if (uy == 0) begin
            dz = 1'b1; q = m; r = ux;
        end else if (o == 3 && sx == -(longint'(1) << (w - 1)) && sy == -1) begin
            ov = 1'b1; q = ux; r = 0;
        end else if (o == 3) begin
            q = sx / sy; r = sx % sy;
        end else begin
            q = ux / uy; r = ux % uy;
        end
        return pack(dz, ov, 32'(r & m), 32'(q & m));
    endfunction

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic do_op(input int k, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input int stall, input logic [65:0] exp);
        int n;
        logic [65:0] snap;
        sel = k;
        @(negedge clk);
        opv = o; av = x; bv = y; in_valid = 1'b1; out_ready = 1'b0;
        check("accept_ready", 96'(ir[sel]), 96'(1));
        @(posedge clk); #1;
        in_valid = 1'b0; opv = 2'($urandom); av = $urandom; bv = $urandom;
        n = 0;
        while (!ovld[sel] && n < 200) begin
            in_valid = 1'($urandom_range(1));
            @(posedge clk); #1;
            n++;
        end
        in_valid = 1'b0;
        check("latency", 96'(n), 96'(wid(k) + 1));
        snap = {dzv[sel], ofv[sel], hi_m, lo_m};
        for (int s = 0; s < stall; s++) begin
            @(posedge clk); #1;
            check("hold", {30'd0, ir[sel], ovld[sel], dzv[sel], ofv[sel], hi_m, lo_m}, {30'd0, 2'b01, snap});
        end
        check("result", 96'({dzv[sel], ofv[sel], hi_m, lo_m}), 96'(exp));
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("handoff", 96'({ir[sel], ovld[sel]}), 96'(2'b10));
    endtask

    initial begin
        logic [1:0] o;
        logic [31:0] x, y;
        int w, r;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            sel = k; #1;
            check("reset_state", {ir[sel], ovld[sel], dzv[sel], ofv[sel], hi_m, lo_m}, {2'b10, 2'b00, 64'd0});
        end
        rst = 1'b0;

        do_op(0, 2'd0, 32'hFF, 32'hFF, 5, pack(1'b0, 1'b0, 32'hFE, 32'h01));
        do_op(0, 2'd1, 32'hFD, 32'h05, 0, pack(1'b0, 1'b0, 32'hFF, 32'hF1));
        do_op(0, 2'd3, 32'hF9, 32'h02, 2, pack(1'b0, 1'b0, 32'hFF, 32'hFD));
        do_op(0, 2'd2, 32'd200, 32'd7, 0, pack(1'b0, 1'b0, 32'h04, 32'h1C));
        do_op(0, 2'd2, 32'h2A, 32'h00, 1, pack(1'b1, 1'b0, 32'h2A, 32'hFF));
        do_op(0, 2'd3, 32'h80, 32'hFF, 0, pack(1'b0, 1'b1, 32'h00, 32'h80));
        do_op(0, 2'd3, 32'h2A, 32'h00, 0, pack(1'b1, 1'b0, 32'h2A, 32'hFF));

        sel = 0;
        @(negedge clk);
        opv = 2'd2; av = 32'd99; bv = 32'd5; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        check("mid_reset", {ir[sel], ovld[sel], dzv[sel], ofv[sel], hi_m, lo_m}, {2'b10, 2'b00, 64'd0});
        rst = 1'b0;
        do_op(0, 2'd2, 32'd99, 32'd5, 0, pack(1'b0, 1'b0, 32'd4, 32'd19));

        for (int k = 0; k < 3; k++) begin
            w = wid(k);
            for (int i = 0; i < (k == 0 ? 300 : 1000); i++) begin
                o = 2'($urandom_range(3));
                x = $urandom;
                y = $urandom;
                r = $urandom_range(9);
                if (r == 0) y = 0;
                if (r == 1) begin
                    o = 2'd3;
                    x = 32'(longint'(1) << (w - 1));
                    y = 32'hFFFF_FFFF;
                end
                do_op(k, o, x, y, $urandom_range(2), model(w, o, x, y));
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
